// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The requester drives start/op/A/B; the unit returns busy/done, the result and its flags.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;
  logic             zero_flag;
  logic             negative_flag;
  logic             overflow_flag;
  logic             div_zero_flag;

  modport master (
    output start, op, A, B,
    input  busy, done, R, zero_flag, negative_flag, overflow_flag, div_zero_flag
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, R, zero_flag, negative_flag, overflow_flag, div_zero_flag
  );
endinterface

// File: rtl/muldiv_unit.sv
// Sequential RISC-V style multiply/divide: one bit per cycle on operand magnitudes,
// with sign correction and result flags registered on the final iteration.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;      // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;      // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_q, r_d;
  logic             zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, dz_q, dz_d;

  logic             in_a_neg, in_b_neg;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic [WIDTH:0]   sum, trial;
  logic [WIDTH-1:0] hi_n, lo_n, res;
  logic [2*WIDTH-1:0] prod;
  logic             load_res, ovf_n, dz_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    r_d      = r_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    load_res = 1'b0;
    res      = '0;
    ovf_n    = 1'b0;
    dz_n     = 1'b0;
    prod     = '0;

    // A is signed for MULH, MULHSU, DIV, REM; B is signed for MULH, DIV, REM.
    in_a_neg = bus.A[WIDTH-1] & ((bus.op == 3'b001) | (bus.op == 3'b010) |
                                 (bus.op == 3'b100) | (bus.op == 3'b110));
    in_b_neg = bus.B[WIDTH-1] & ((bus.op == 3'b001) | (bus.op == 3'b100) |
                                 (bus.op == 3'b110));
    in_mag_a = in_a_neg ? -bus.A : bus.A;
    in_mag_b = in_b_neg ? -bus.B : bus.B;

    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!op_q[2]) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      hi_n = trial[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_n = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      lo_n = {lo_q[WIDTH-2:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_neg_d = in_a_neg;
          b_neg_d = in_b_neg;
          cnt_d   = '0;
          if (bus.op[2] && (bus.B == '0)) begin
            load_res = 1'b1;
            dz_n     = 1'b1;
            res      = bus.op[1] ? bus.A : '1;
            state_d  = DONE;
          end else if (bus.op[2] && !bus.op[0] && (bus.A == MOST_NEG) && (bus.B == '1)) begin
            load_res = 1'b1;
            ovf_n    = 1'b1;
            res      = bus.op[1] ? '0 : bus.A;
            state_d  = DONE;
          end else begin
            hi_d    = '0;
            lo_d    = bus.op[2] ? in_mag_a : in_mag_b;
            opnd_d  = bus.op[2] ? in_mag_b : in_mag_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          load_res = 1'b1;
          state_d  = DONE;
          if (!op_q[2]) begin
            prod = {hi_n, lo_n};
            if (a_neg_q ^ b_neg_q) prod = -prod;
            res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
          end else if (op_q[1]) begin
            res = a_neg_q ? -hi_n : hi_n;
          end else begin
            res = (a_neg_q ^ b_neg_q) ? -lo_n : lo_n;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load_res) begin
      r_d    = res;
      zero_d = ~|res;
      neg_d  = res[WIDTH-1];
      ovf_d  = ovf_n;
      dz_d   = dz_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      r_q     <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      r_q     <= r_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy          = (state_q == CALC);
  assign bus.done          = (state_q == DONE);
  assign bus.R             = r_q;
  assign bus.zero_flag     = zero_q;
  assign bus.negative_flag = neg_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.div_zero_flag = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks for muldiv_unit at WIDTH=32: vector table plus abort and
// ignored-start sequences.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;

  muldiv_unit_if #(.WIDTH(32)) bus();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic [3:0]  exp_flags;  // {zero, negative, overflow, div_zero}
    int          exp_lat;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.zero_flag, bus.negative_flag, bus.overflow_flag, bus.div_zero_flag};
  endfunction

  // Called #1 after a rising edge with the unit idle; returns #1 after the DONE edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_bad);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.A     = ~a;
    bus.B     = ~b;
    lat       = 1;
    busy_bad  = 0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy) busy_bad++;
  endtask

  vec_t vecs[17];
  int   lat, busy_bad, dcount;
  logic [31:0] prev_r;

  initial begin
    vecs[0]  = '{"mul_7_neg3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0100, 33};
    vecs[1]  = '{"mul_shift",       3'b000, 32'h12345678, 32'h10,       32'h23456780, 4'b0000, 33};
    vecs[2]  = '{"mulh_min_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, 33};
    vecs[3]  = '{"mulh_m1_m1",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 33};
    vecs[4]  = '{"mulhu_max_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 33};
    vecs[5]  = '{"mulhsu_m1_max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0100, 33};
    vecs[6]  = '{"div_m7_2",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b0100, 33};
    vecs[7]  = '{"rem_m7_2",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b0100, 33};
    vecs[8]  = '{"div_7_m2",        3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0100, 33};
    vecs[9]  = '{"rem_7_m2",        3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        4'b0000, 33};
    vecs[10] = '{"divu_100_7",      3'b101, 32'd100,      32'd7,        32'd14,       4'b0000, 33};
    vecs[11] = '{"remu_100_7",      3'b111, 32'd100,      32'd7,        32'd2,        4'b0000, 33};
    vecs[12] = '{"remu_14_7",       3'b111, 32'd14,       32'd7,        32'd0,        4'b1000, 33};
    vecs[13] = '{"divu_5_0",        3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0101, 1};
    vecs[14] = '{"rem_5_0",         3'b110, 32'd5,        32'd0,        32'd5,        4'b0001, 1};
    vecs[15] = '{"div_ovf",         3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0110, 1};
    vecs[16] = '{"rem_ovf",         3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b1010, 1};

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    chk("reset_busy",  {31'd0, bus.busy}, 32'd0);
    chk("reset_done",  {31'd0, bus.done}, 32'd0);
    chk("reset_R",     bus.R, 32'd0);
    chk("reset_flags", {28'd0, flags()}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_bad);
      $display("op=%0d %s A=0x%08h B=0x%08h R=0x%08h flags=%b lat=%0d",
               vecs[i].op, vecs[i].name, vecs[i].a, vecs[i].b, bus.R, flags(), lat);
      chk({vecs[i].name, "_R"},     bus.R, vecs[i].exp_r);
      chk({vecs[i].name, "_flags"}, {28'd0, flags()}, {28'd0, vecs[i].exp_flags});
      chk({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
      chk({vecs[i].name, "_busy"},  busy_bad, 0);
      @(posedge clk); #1;
    end

    // Start pulsed mid-CALC and again during DONE must both be ignored.
    bus.start = 1'b1; bus.op = 3'b000; bus.A = 32'd7; bus.B = 32'hFFFFFFFD;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 5) begin
        bus.start = 1'b1; bus.op = 3'b101; bus.A = 32'd100; bus.B = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    $display("ignored_start R=0x%08h lat=%0d", bus.R, lat);
    chk("ign_busy_R",   bus.R, 32'hFFFFFFEB);
    chk("ign_busy_lat", lat, 33);
    bus.start = 1'b1; bus.op = 3'b101; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_done_busy", {31'd0, bus.busy}, 32'd0);
    chk("ign_done_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("ign_hold_R", bus.R, 32'hFFFFFFEB);

    // Reset during CALC cycle 10 aborts with no trailing done.
    prev_r = bus.R;
    bus.start = 1'b1; bus.op = 3'b101; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk); #1;
    chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    chk("abort_R_before",    bus.R, prev_r);
    #2 rst_n = 1'b0;
    #1;
    $display("abort busy=%0d done=%0d R=0x%08h", bus.busy, bus.done, bus.R);
    chk("abort_busy",  {31'd0, bus.busy}, 32'd0);
    chk("abort_R",     bus.R, 32'd0);
    chk("abort_flags", {28'd0, flags()}, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dcount++;
    end
    chk("abort_no_done", dcount, 0);

    run_op(3'b101, 32'd100, 32'd7, lat, busy_bad);
    $display("after_abort divu R=0x%08h lat=%0d", bus.R, lat);
    chk("post_abort_R",   bus.R, 32'd14);
    chk("post_abort_lat", lat, 33);
    chk("post_abort_busy", busy_bad, 0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
